// File: rtl/dma_sequencer_n.sv
// Multi-channel DMA request sequencer: arbitrates per-channel requests (bounded burst
// round-robin), muxes the granted channel onto a single DMA controller port.
module dma_sequencer_n #(
  parameter int DEVNUM = 4,
  parameter int AW     = 21,
  parameter int DW     = 8,
  parameter int BURST  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DEVNUM-1:0]    req,
  input  logic [DEVNUM-1:0]    en,
  input  logic [DEVNUM*AW-1:0] addr,
  input  logic [DEVNUM-1:0]    rnw,
  input  logic [DEVNUM*DW-1:0] wd,
  output logic [DEVNUM-1:0]    ack,
  output logic [DEVNUM-1:0]    done,
  output logic [DW-1:0]        rd,
  output logic [DEVNUM-1:0]    grant,
  output logic                 busy,
  output logic                 dma_req,
  output logic [AW-1:0]        dma_addr,
  output logic                 dma_rnw,
  output logic [DW-1:0]        dma_wd,
  input  logic [DW-1:0]        dma_rd,
  input  logic                 dma_ack,
  input  logic                 dma_end
);

  localparam int CW = $clog2(BURST + 1);
  localparam int IW = $clog2(DEVNUM);

  // Handshake: dma_req is high while the granted channel holds req; a cycle with
  // dma_ack high accepts the muxed request, and dma_end later closes the acked transfer.
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [DEVNUM-1:0] r_grant, w_grant_nxt;
  logic [DEVNUM-1:0] r_osel;
  logic [CW-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [DEVNUM-1:0] w_reqe, w_low, w_rr;
  logic [IW-1:0]     w_gidx;
  logic              w_own_req;

  assign w_reqe    = req & en;
  assign w_own_req = |(r_grant & w_reqe);
  assign w_cnt_inc = r_cnt + CW'(1);

  // With no grant the index defaults to the top channel, so the scan starts at channel 0.
  always_comb begin
    w_gidx = IW'(DEVNUM - 1);
    for (int i = 0; i < DEVNUM; i++)
      if (r_grant[i]) w_gidx = IW'(i);
  end

  always_comb begin
    w_low = '0;
    for (int i = DEVNUM - 1; i >= 0; i--)
      if (w_reqe[i]) begin
        w_low    = '0;
        w_low[i] = 1'b1;
      end
  end

  always_comb begin : rr_scan
    int   v_idx;
    logic v_found;
    w_rr    = '0;
    v_found = 1'b0;
    v_idx   = 0;
    for (int k = 1; k <= DEVNUM; k++) begin
      v_idx = int'(w_gidx) + k;
      if (v_idx >= DEVNUM) v_idx = v_idx - DEVNUM;
      if (!v_found && w_reqe[IW'(v_idx)]) begin
        w_rr[IW'(v_idx)] = 1'b1;
        v_found          = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_grant_nxt = w_low;
        w_cnt_nxt   = '0;
        if (|w_reqe) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (!dma_req) w_state_nxt = S_IDLE;
        if (dma_ack) begin
          if (w_own_req && (w_cnt_inc < CW'(BURST))) begin
            w_cnt_nxt = w_cnt_inc;
          end else begin
            w_grant_nxt = w_rr;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_cnt   <= '0;
      r_osel  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_cnt   <= w_cnt_nxt;
      if (dma_ack) r_osel <= r_grant;
    end
  end

  // done follows the channel captured at ack time, not the live grant.
  always_comb begin
    dma_addr = '0;
    dma_wd   = '0;
    for (int i = 0; i < DEVNUM; i++)
      if (r_grant[i]) begin
        dma_addr = dma_addr | addr[i*AW +: AW];
        dma_wd   = dma_wd | wd[i*DW +: DW];
      end
  end

  assign dma_req = |(r_grant & req);
  assign dma_rnw = (r_grant == '0) ? 1'b1 : |(r_grant & rnw);
  assign ack     = r_grant & {DEVNUM{dma_ack}};
  assign done    = r_osel & {DEVNUM{dma_end}};
  assign rd      = dma_rd;
  assign grant   = r_grant;
  assign busy    = (r_state == S_BUSY);

endmodule

// File: tb/tb_dma_sequencer_n.sv
// Bench for dma_sequencer_n: two instances (BURST=2 and BURST=1) driven in parallel,
// directed vector table, hand sequences, then random traffic against a reference model.
module tb_dma_sequencer_n;
  localparam int N  = 4;
  localparam int AW = 21;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req, en, rnw;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wd;
  logic [DW-1:0]   dma_rd;
  logic            dma_ack, dma_end;

  logic [N-1:0]  a_ack, a_done, a_grant, b_ack, b_done, b_grant;
  logic [DW-1:0] a_rd, a_dma_wd, b_rd, b_dma_wd;
  logic [AW-1:0] a_dma_addr, b_dma_addr;
  logic          a_busy, a_dma_req, a_dma_rnw, b_busy, b_dma_req, b_dma_rnw;

  dma_sequencer_n #(.DEVNUM(N), .AW(AW), .DW(DW), .BURST(2)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req), .en(en), .addr(addr), .rnw(rnw), .wd(wd),
    .ack(a_ack), .done(a_done), .rd(a_rd), .grant(a_grant), .busy(a_busy),
    .dma_req(a_dma_req), .dma_addr(a_dma_addr), .dma_rnw(a_dma_rnw), .dma_wd(a_dma_wd),
    .dma_rd(dma_rd), .dma_ack(dma_ack), .dma_end(dma_end));

  dma_sequencer_n #(.DEVNUM(N), .AW(AW), .DW(DW), .BURST(1)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req), .en(en), .addr(addr), .rnw(rnw), .wd(wd),
    .ack(b_ack), .done(b_done), .rd(b_rd), .grant(b_grant), .busy(b_busy),
    .dma_req(b_dma_req), .dma_addr(b_dma_addr), .dma_rnw(b_dma_rnw), .dma_wd(b_dma_wd),
    .dma_rd(dma_rd), .dma_ack(dma_ack), .dma_end(dma_end));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: channel indices (-1 = none) and plain integer counters.
  int burst [2] = '{2, 1};
  int m_g   [2];
  int m_cnt [2];
  int m_os  [2];
  bit m_busy[2];

  function automatic logic [3:0] oh(int i);
    logic [3:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int lowest(logic [3:0] re);
    for (int i = 0; i < N; i++) if (re[i]) return i;
    return -1;
  endfunction

  function automatic int next_rr(int g, logic [3:0] re);
    if (g < 0) return lowest(re);
    for (int j = 1; j <= N; j++) begin
      int ix;
      ix = (g + j) % N;
      if (re[ix]) return ix;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_g[k] = -1; m_cnt[k] = 0; m_os[k] = -1; m_busy[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [3:0] re;
    re = req & en;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      int g;
      bit dq;
      g  = m_g[k];
      dq = (g >= 0) && req[g];
      if (!m_busy[k]) begin
        m_g[k]    = lowest(re);
        m_cnt[k]  = 0;
        m_busy[k] = (re != 0);
      end else begin
        m_busy[k] = dq;
        if (dma_ack) begin
          if (g >= 0 && re[g] && (m_cnt[k] + 1 < burst[k])) m_cnt[k]++;
          else begin
            m_g[k]   = next_rr(g, re);
            m_cnt[k] = 0;
          end
        end
      end
      if (dma_ack) m_os[k] = g;
    end
  endtask

  task automatic cmp_inst(int k, logic [3:0] g, logic [3:0] ak, logic [3:0] dn, logic bsy,
                          logic dq, logic [AW-1:0] da, logic dr, logic [DW-1:0] dw,
                          logic [DW-1:0] rdv);
    string p;
    int gi;
    logic [AW-1:0] e_da;
    logic [DW-1:0] e_dw;
    p  = k ? "B" : "A";
    gi = m_g[k];
    e_da = (gi >= 0) ? addr[gi*AW +: AW] : '0;
    e_dw = (gi >= 0) ? wd[gi*DW +: DW] : '0;
    chk({p, "_model_grant"}, 32'(g), 32'(oh(gi)));
    chk({p, "_model_busy"}, 32'(bsy), 32'(m_busy[k]));
    chk({p, "_model_ack"}, 32'(ak), 32'(dma_ack ? oh(gi) : 4'b0));
    chk({p, "_model_done"}, 32'(dn), 32'(dma_end ? oh(m_os[k]) : 4'b0));
    chk({p, "_model_dma_req"}, 32'(dq), 32'((gi >= 0) && req[gi]));
    chk({p, "_model_dma_addr"}, 32'(da), 32'(e_da));
    chk({p, "_model_dma_rnw"}, 32'(dr), 32'((gi >= 0) ? rnw[gi] : 1'b1));
    chk({p, "_model_dma_wd"}, 32'(dw), 32'(e_dw));
    chk({p, "_model_rd"}, 32'(rdv), 32'(dma_rd));
  endtask

  // Caller sets inputs at the falling edge and waits #1 before calling.
  task automatic tick();
    if (!rst_n) model_reset();
    cmp_inst(0, a_grant, a_ack, a_done, a_busy, a_dma_req, a_dma_addr, a_dma_rnw, a_dma_wd, a_rd);
    cmp_inst(1, b_grant, b_ack, b_done, b_busy, b_dma_req, b_dma_addr, b_dma_rnw, b_dma_wd, b_rd);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic       rst_n;
    logic [3:0] req, en;
    logic       ack, dend;
    logic [3:0] g, ak, dn;
    logic       busy, dreq;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] e, logic a, logic d,
                              logic [3:0] g, logic [3:0] ak, logic [3:0] dn, logic b, logic dq);
    vec_t v;
    v.rst_n = r; v.req = rq; v.en = e; v.ack = a; v.dend = d;
    v.g = g; v.ak = ak; v.dn = dn; v.busy = b; v.dreq = dq;
    return v;
  endfunction

  logic [3:0] ord35 [9] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1};
  logic [3:0] exp36 [4] = '{4'h1, 4'h4, 4'h1, 4'h4};

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req = '0; en = 4'hF; rnw = 4'b1010;
    addr = (N*AW)'({$urandom, $urandom, $urandom});
    wd = $urandom; dma_rd = 8'h5A; dma_ack = 1'b0; dma_end = 1'b0;
    model_reset();
    @(negedge clk);

    // Round-robin with burst of two, all channels requesting, ack every second cycle.
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0));
    for (int c = 0; c <= 18; c++) begin
      logic a;
      logic [3:0] g;
      a = (c >= 2) && (c % 2 == 0);
      g = (c == 0) ? 4'h0 : ord35[(c - 1) / 2];
      tbl.push_back(mk(1, 4'hF, 4'hF, a, 0, g, a ? g : 4'h0, 4'h0, c >= 1, c >= 1));
    end
    // done tracks the acked channel after the grant moves on.
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 4'hA, 4'hF, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 4'hA, 4'hF, 1, 0, 4'h2, 4'h2, 4'h0, 1, 1));
    tbl.push_back(mk(1, 4'hA, 4'hF, 0, 0, 4'h2, 4'h0, 4'h0, 1, 1));
    tbl.push_back(mk(1, 4'hA, 4'hF, 1, 0, 4'h2, 4'h2, 4'h0, 1, 1));
    tbl.push_back(mk(1, 4'h8, 4'hF, 0, 0, 4'h8, 4'h0, 4'h0, 1, 1));
    tbl.push_back(mk(1, 4'h8, 4'hF, 0, 0, 4'h8, 4'h0, 4'h0, 1, 1));
    tbl.push_back(mk(1, 4'h8, 4'hF, 0, 1, 4'h8, 4'h0, 4'h2, 1, 1));
    // Enable masks arbitration only; a granted channel keeps its request until ack.
    tbl.push_back(mk(0, 4'h0, 4'hE, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 4'h3, 4'hE, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 4'h3, 4'hC, 0, 0, 4'h2, 4'h0, 4'h0, 1, 1));
    tbl.push_back(mk(1, 4'h3, 4'hC, 1, 0, 4'h2, 4'h2, 4'h0, 1, 1));
    tbl.push_back(mk(1, 4'h1, 4'hC, 0, 0, 4'h0, 4'h0, 4'h0, 1, 0));
    tbl.push_back(mk(1, 4'h1, 4'hC, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0));

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; req = tbl[i].req; en = tbl[i].en;
      dma_ack = tbl[i].ack; dma_end = tbl[i].dend;
      #1;
      chk($sformatf("row%0d_grant", i), 32'(a_grant), 32'(tbl[i].g));
      chk($sformatf("row%0d_ack", i), 32'(a_ack), 32'(tbl[i].ak));
      chk($sformatf("row%0d_done", i), 32'(a_done), 32'(tbl[i].dn));
      chk($sformatf("row%0d_busy", i), 32'(a_busy), 32'(tbl[i].busy));
      chk($sformatf("row%0d_dma_req", i), 32'(a_dma_req), 32'(tbl[i].dreq));
      tick();
    end
    dma_ack = 1'b0; dma_end = 1'b0; en = 4'hF;

    // Single-cycle request from idle, then async reset while channel 2 is granted.
    rst_n = 1'b0; req = 4'h0; #1; tick();
    rst_n = 1'b1; req = 4'b1010; #1; tick();
    req = 4'b0000; #1;
    chk("idle_grant_ch1", 32'(a_grant), 32'h2);
    chk("idle_busy", 32'(a_busy), 32'h1);
    chk("idle_addr_ch1", 32'(a_dma_addr), 32'(addr[1*AW +: AW]));
    tick(); tick();
    rnw = 4'b1011; req = 4'b0100; #1; tick();
    #1;
    chk("busy_grant_ch2", 32'(a_grant), 32'h4);
    chk("busy_rnw_ch2", 32'(a_dma_rnw), 32'h0);
    chk("busy_wd_ch2", 32'(a_dma_wd), 32'(wd[2*DW +: DW]));
    tick();
    rst_n = 1'b0; #1;
    chk("rst_grant", 32'(a_grant), 32'h0);
    chk("rst_busy", 32'(a_busy), 32'h0);
    chk("rst_rnw", 32'(a_dma_rnw), 32'h1);
    chk("rst_dma_req", 32'(a_dma_req), 32'h0);
    tick();
    rst_n = 1'b1; req = 4'h0; dma_end = 1'b1; #1;
    chk("post_rst_done_a", 32'(a_done), 32'h0);
    chk("post_rst_done_b", 32'(b_done), 32'h0);
    tick();
    dma_end = 1'b0;

    // Pure per-transfer round-robin on the BURST=1 instance.
    rst_n = 1'b0; #1; tick();
    rst_n = 1'b1; req = 4'b0101; #1; tick();
    for (int j = 0; j < 4; j++) begin
      dma_ack = 1'b1; #1;
      chk($sformatf("b1_rr_ack%0d", j), 32'(b_ack), 32'(exp36[j]));
      tick();
    end
    dma_ack = 1'b0; rst_n = 1'b0; #1; tick();
    rst_n = 1'b1; req = 4'b0100; #1; tick();
    for (int j = 0; j < 3; j++) begin
      dma_ack = 1'b1; #1;
      chk($sformatf("b1_sole_ack%0d", j), 32'(b_ack), 32'h4);
      tick();
    end
    dma_ack = 1'b0; #1;
    chk("b1_sole_grant", 32'(b_grant), 32'h4);
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      en      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      rnw     = 4'($urandom);
      addr    = (N*AW)'({$urandom, $urandom, $urandom});
      wd      = (N*DW)'($urandom);
      dma_rd  = 8'($urandom);
      dma_ack = ($urandom_range(0, 2) == 0);
      dma_end = ($urandom_range(0, 3) == 0);
      rst_n   = ($urandom_range(0, 99) != 0);
      #1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_sequencer_n.md
DMA_SEQUENCER_N -- requirements
Module: dma_sequencer_n

Interface
REQ-001 Parameter DEVNUM, default 4: number of requesting channels, 2..16.
REQ-002 Parameter AW, default 21: DMA address width.
REQ-003 Parameter DW, default 8: DMA data width.
REQ-004 Parameter BURST, default 1: max consecutive acks granted to one channel while others wait, 1..15; BURST=1 is pure per-transfer round-robin.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req  in  DEVNUM  per-channel request, bit i = channel i.
REQ-008 en  in  DEVNUM  per-channel arbitration enable.
REQ-009 addr  in  DEVNUM*AW  flattened addresses, channel i at [i*AW +: AW].
REQ-010 rnw  in  DEVNUM  per-channel read(1)/write(0).
REQ-011 wd  in  DEVNUM*DW  flattened write data, channel i at [i*DW +: DW].
REQ-012 ack  out  DEVNUM  per-channel acknowledge.
REQ-013 done  out  DEVNUM  per-channel end-of-transfer.
REQ-014 rd  out  DW  read data, common to all channels.
REQ-015 grant  out  DEVNUM  one-hot or zero, current input-mux selection.
REQ-016 busy  out  1  sequencer busy flag.
REQ-017 dma_req, dma_addr(AW), dma_rnw, dma_wd(DW)  out: muxed request to DMA controller.
REQ-018 dma_rd(DW), dma_ack, dma_end  in: DMA controller responses.

Function
REQ-019 Effective request reqe = req & en; en affects arbitration only, never an already-granted channel's pass-through.
REQ-020 Two states: IDLE (busy=0), BUSY (busy=1); IDLE->BUSY when |reqe; BUSY->IDLE when dma_req=0; each transition takes effect at the next edge.
REQ-021 grant SHALL update in IDLE every cycle, and in BUSY only on a dma_ack cycle; otherwise hold.
REQ-022 IDLE selection: lowest-index channel with reqe set, zero if none; burst counter cleared.
REQ-023 On dma_ack, cnt_next = cnt+1; if reqe of the granted channel is set and cnt_next < BURST, grant holds and cnt <= cnt_next.
REQ-024 Otherwise round-robin: first channel with reqe set scanning upward from granted index+1, wrapping, the granted channel itself last; cnt <= 0; zero if no reqe.
REQ-025 Combinational muxing: dma_req = |(grant & req); dma_addr and dma_wd = selected channel's fields, 0 when grant=0; dma_rnw = selected rnw, 1 when grant=0.
REQ-026 ack = grant & {DEVNUM{dma_ack}}, same cycle.
REQ-027 Output selection osel <= grant on each dma_ack; done = osel & {DEVNUM{dma_end}}; osel holds otherwise, so done follows the acked channel even after grant moves.
REQ-028 rd = dma_rd, no muxing or register.
REQ-029 Requester holds req, addr, rnw, wd stable until its ack; requester withdrawal before ack drops dma_req and busy falls next cycle.
REQ-030 dma_ack and dma_end in the same cycle: done uses osel before the update, ack uses current grant.
REQ-031 Counter width ceil(log2(BURST+1)); never exceeds BURST-1.

Reset
REQ-032 While rst_n=0: busy=0, grant=0, osel=0, cnt=0; hence dma_req=0, dma_addr=0, dma_wd=0, dma_rnw=1, ack=0, done=0.
REQ-033 Reset asserted mid-transfer SHALL clear all state immediately; a pending dma_end after reset release produces no done.

Verification (DEVNUM=4, BURST=2 unless stated)
REQ-034 Idle, req=4'b1010 asserted in one cycle -> grant=4'b0010, busy=1 next edge, dma_addr=addr1.
REQ-035 req=4'b1111 held, dma_ack every 2nd cycle -> ack order ch0,ch0,ch1,ch1,ch2,ch2,ch3,ch3,ch0.
REQ-036 BURST=1, req=4'b0101 held -> ack order ch0,ch2,ch0,ch2; sole requester ch2 -> ch2 regranted each ack.
REQ-037 ch1 acked, grant moves to ch3, dma_end 3 cycles later -> done=4'b0010, not 4'b1000.
REQ-038 en=4'b1110, req=4'b0011 from idle -> grant=4'b0010; en[1] cleared while granted -> dma_req stays 1 until ack.
REQ-039 rst_n pulsed low during BUSY with grant=4'b0100 -> grant=0, busy=0, dma_rnw=1 asynchronously; dma_end after release -> done=0.
